cpu_sequencer: RTL

Parametrised micro-sequencer for the SAP CPU. It generates the per-cycle control word from the instruction register opcode, a T-state counter and the ALU flags. Instructions run a variable number of T-states, ending early on an END microword bit. The block adds a HALT state, a memory-wait stall, and flag-conditional microsteps with selectable flag and polarity. It sits between the instruction register and every register/bus enable in the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/cpu_microcode_rom.sv | 74 +++++++
 rtl/cpu_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the SAP CPU micro-sequencer: control bit positions,
// opcode map, microword layout helpers and the sequencer state type.
`timescale 1ns/1ps
package cpu_ctrl_pkg;

    // Control line bit positions within the control word.
    localparam int EP = 0;
    localparam int LM = 1;
    localparam int C  = 2;
    localparam int LI = 3;
    localparam int EM = 4;
    localparam int LA = 5;
    localparam int LB = 6;
    localparam int LC = 7;
    localparam int LD = 8;
    localparam int EA = 9;
    localparam int EB = 10;
    localparam int EI = 11;
    localparam int ES = 12;
    localparam int LO = 13;
    localparam int LP = 14;

    // Opcode map; anything not listed decodes as a NOP.
    localparam int unsigned OPC_NOP    = 0;
    localparam int unsigned OPC_LD_A   = 1;
    localparam int unsigned OPC_LD_B   = 2;
    localparam int unsigned OPC_ADD_A  = 3;
    localparam int unsigned OPC_OUT_A  = 4;
    localparam int unsigned OPC_LDM_A  = 5;
    localparam int unsigned OPC_JMP    = 6;
    localparam int unsigned OPC_JMP_CN = 8;
    localparam int unsigned OPC_JMP_ZE = 9;
    localparam int unsigned OPC_LONG   = 10;
    localparam int unsigned OPC_HLT    = 15;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

    // Microword layout, LSB first: ctrl, end, cond_en, cond_pol, cond_sel.
    function automatic int sel_w(input int flag_w);
        return (flag_w > 1) ? $clog2(flag_w) : 1;
    endfunction

    function automatic int mw_end_ofs(input int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int mw_cen_ofs(input int ctrl_w);
        return ctrl_w + 1;
    endfunction

    function automatic int mw_pol_ofs(input int ctrl_w);
        return ctrl_w + 2;
    endfunction

    function automatic int mw_sel_ofs(input int ctrl_w);
        return ctrl_w + 3;
    endfunction

    function automatic int MW_W(input int ctrl_w, input int flag_w);
        return ctrl_w + 3 + sel_w(flag_w);
    endfunction

endpackage

// File: rtl/cpu_microcode_rom.sv
// Combinational microcode store: (opcode, execute step) -> microword.
// Step 0 here corresponds to t_state 2, the first step after fetch.
`timescale 1ns/1ps
module cpu_microcode_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 15,
    parameter int FLAG_W = 2,
    parameter int MAX_T  = 6,
    localparam int T_W   = $clog2(MAX_T),
    localparam int SEL_W = sel_w(FLAG_W),
    localparam int MWW   = MW_W(CTRL_W, FLAG_W)
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [T_W-1:0]   step,
    output logic [MWW-1:0]   microword
);

    localparam logic [T_W-1:0] S0 = T_W'(0);
    localparam logic [T_W-1:0] S1 = T_W'(1);
    localparam logic [T_W-1:0] S2 = T_W'(2);
    localparam logic [T_W-1:0] S3 = T_W'(3);

    function automatic logic [CTRL_W-1:0] cb(input int pos);
        return CTRL_W'(1) << pos;
    endfunction

    function automatic logic [MWW-1:0] mw(input logic [CTRL_W-1:0] ctrl, input logic end_b,
                                          input logic cen, input logic pol,
                                          input logic [SEL_W-1:0] sel);
        return {sel, pol, cen, end_b, ctrl};
    endfunction

    always_comb begin
        // Unused steps and undefined opcodes end immediately with no control lines.
        microword = mw('0, 1'b1, 1'b0, 1'b0, '0);
        case (opcode)
            OPC_W'(OPC_LD_A):  if (step == S0) microword = mw(cb(LA) | cb(EI), 1'b1, 1'b0, 1'b0, '0);
            OPC_W'(OPC_LD_B):  if (step == S0) microword = mw(cb(LB) | cb(EI), 1'b1, 1'b0, 1'b0, '0);
            OPC_W'(OPC_OUT_A): if (step == S0) microword = mw(cb(EA) | cb(LO), 1'b1, 1'b0, 1'b0, '0);
            OPC_W'(OPC_JMP):   if (step == S0) microword = mw(cb(EI) | cb(LP), 1'b1, 1'b0, 1'b0, '0);
            OPC_W'(OPC_ADD_A): begin
                case (step)
                    S0:      microword = mw(cb(EI) | cb(LB), 1'b0, 1'b0, 1'b0, '0);
                    S1:      microword = mw(cb(ES) | cb(LA), 1'b1, 1'b0, 1'b0, '0);
                    default: ;
                endcase
            end
            OPC_W'(OPC_LDM_A): begin
                case (step)
                    S0:      microword = mw(cb(EI) | cb(LM), 1'b0, 1'b0, 1'b0, '0);
                    S1:      microword = mw(cb(EM) | cb(LA), 1'b1, 1'b0, 1'b0, '0);
                    default: ;
                endcase
            end
            // Conditional jumps: carry is flag 0, zero is flag 1, jump when set.
            OPC_W'(OPC_JMP_CN): if (step == S0) microword = mw(cb(EI) | cb(LP), 1'b1, 1'b1, 1'b1, SEL_W'(0));
            OPC_W'(OPC_JMP_ZE): if (step == S0) microword = mw(cb(EI) | cb(LP), 1'b1, 1'b1, 1'b1, SEL_W'(1));
            // Never sets end; relies on the MAX_T-1 wrap to terminate.
            OPC_W'(OPC_LONG): begin
                case (step)
                    S0:      microword = mw(cb(EA) | cb(LB), 1'b0, 1'b0, 1'b0, '0);
                    S1:      microword = mw(cb(EB) | cb(LC), 1'b0, 1'b0, 1'b0, '0);
                    S2:      microword = mw(cb(EA) | cb(LD), 1'b0, 1'b0, 1'b0, '0);
                    S3:      microword = mw(cb(EB) | cb(LO), 1'b0, 1'b0, 1'b0, '0);
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// SAP CPU micro-sequencer: fixed fetch, ROM-driven execute steps, memory stall,
// flag-conditional steps and a HALT state left by a resume pulse.
`timescale 1ns/1ps
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int CTRL_W = 15,
    parameter int FLAG_W = 2,
    parameter int MAX_T  = 6,
    localparam int T_W   = $clog2(MAX_T)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  ir_opcode,
    input  logic [FLAG_W-1:0] flags,
    input  logic              mem_ready,
    input  logic              resume,
    output logic [CTRL_W-1:0] control_lines,
    output logic [T_W-1:0]    t_state,
    output logic              halted,
    output logic              instr_done,
    output seq_state_e        state_dbg
);

    localparam int SEL_W   = sel_w(FLAG_W);
    localparam int MWW     = MW_W(CTRL_W, FLAG_W);
    localparam int END_OFS = mw_end_ofs(CTRL_W);
    localparam int CEN_OFS = mw_cen_ofs(CTRL_W);
    localparam int POL_OFS = mw_pol_ofs(CTRL_W);
    localparam int SEL_OFS = mw_sel_ofs(CTRL_W);

    localparam logic [CTRL_W-1:0] FETCH0 = (CTRL_W'(1) << EP) | (CTRL_W'(1) << LM);
    localparam logic [CTRL_W-1:0] FETCH1 = (CTRL_W'(1) << C) | (CTRL_W'(1) << LI) | (CTRL_W'(1) << EM);
    localparam logic [T_W-1:0]    T_LAST = T_W'(MAX_T - 1);

    seq_state_e        state_q, state_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [T_W-1:0]    step;
    logic [MWW-1:0]    mw;
    logic [CTRL_W-1:0] ctrl_raw, ctrl_out;
    logic              end_raw, last_step, cond_ok, stall, done_out;

    assign step = t_q - T_W'(2);

    cpu_microcode_rom #(
        .OPC_W (OPC_W),
        .CTRL_W(CTRL_W),
        .FLAG_W(FLAG_W),
        .MAX_T (MAX_T)
    ) u_rom (
        .opcode   (ir_opcode),
        .step     (step),
        .microword(mw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // mem_ready is a level: a step touching memory (EM or LM) only completes
    // in a cycle where it is high. resume is sampled only while halted.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        ctrl_raw  = '0;
        end_raw   = 1'b0;
        last_step = 1'b0;
        stall     = 1'b0;
        ctrl_out  = '0;
        done_out  = 1'b0;
        cond_ok   = (flags[mw[SEL_OFS +: SEL_W]] == mw[POL_OFS]);
        case (state_q)
            ST_RUN: begin
                if (t_q == T_W'(0)) begin
                    ctrl_raw = FETCH0;
                end else if (t_q == T_W'(1)) begin
                    ctrl_raw = FETCH1;
                end else if (mw[CEN_OFS] && !cond_ok) begin
                    end_raw = 1'b1;
                end else begin
                    ctrl_raw = mw[CTRL_W-1:0];
                    end_raw  = mw[END_OFS];
                end
                last_step = end_raw || (t_q == T_LAST);
                stall     = !mem_ready && (ctrl_raw[EM] || ctrl_raw[LM]);
                // HALT is decided before the stall so a halting step never waits.
                if ((t_q == T_W'(2)) && (ir_opcode == OPC_W'(OPC_HLT))) begin
                    state_d  = ST_HALT;
                    t_d      = '0;
                    ctrl_out = ctrl_raw;
                    done_out = 1'b1;
                end else if (!stall) begin
                    ctrl_out = ctrl_raw;
                    done_out = last_step;
                    t_d      = last_step ? '0 : t_q + T_W'(1);
                end
            end
            ST_HALT: begin
                t_d = '0;
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs are gated by rst so they drop the moment reset asserts.
    assign control_lines = rst ? ctrl_out : '0;
    assign instr_done    = rst & done_out;
    assign t_state       = t_q;
    assign halted        = (state_q == ST_HALT);
    assign state_dbg     = state_q;

endmodule
